// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter
//   Shares one 4-bit maximal-length Fibonacci LFSR (x^4+x^3+1, period 15)
//   between NUM_REQ requesters. Round-robin arbitration hands out one
//   pseudo-random nibble per grant. A runtime seed load overrides the
//   generator state. An all-zero seed is replaced by SEED.
//
//   Optional build macro: LFSR_ARB_FREE_RUN_EN
//     defined   : the LFSR steps on every edge not taken by reset or seed load.
//     undefined : the LFSR steps only when a grant cycle ends.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   req_i        per-requester request, held until granted
//   seed_i       runtime seed value
//   seed_load_i  one-cycle strobe that loads seed_i (or SEED if seed_i==0)
//   gnt_o        one-hot grant, one-cycle pulse
//   gnt_id_o     index of the granted requester (valid with rnd_vld_o)
//   rnd_o        random nibble delivered with the grant; held between grants
//   rnd_vld_o    high in the grant cycle
//   busy_o       high while the FSM is in GNT
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a request; a seed load in this cycle blocks the grant
//   GNT   | grant outputs asserted for one cycle; always returns to IDLE

module lfsr_rng_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter logic [3:0] SEED    = 4'hE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [3:0]         seed_i,
  input  logic               seed_load_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         gnt_id_o,
  output logic [3:0]         rnd_o,
  output logic               rnd_vld_o,
  output logic               busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] q;
  logic [3:0] q_next;
  logic [3:0] q_seed;
  logic [2:0] ptr;
  logic [2:0] ptr_next;
  logic [2:0] win;
  logic [2:0] win_hi;
  logic [2:0] win_lo;
  logic       found_hi;
  logic       any_req;

  assign q_next  = {q[2:0], q[3] ^ q[2]};
  assign q_seed  = (seed_i == 4'h0) ? SEED : seed_i;
  assign any_req = |req_i;

  // Round-robin pick: lowest set request at or above ptr wins; if none is
  // there, wrap around and take the lowest set request below ptr. Scanning
  // downward lets the last hit in each half be the lowest index.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = 3'd0;
    win_lo   = 3'd0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        if (j >= int'(ptr)) begin
          found_hi = 1'b1;
          win_hi   = 3'(j);
        end else begin
          win_lo = 3'(j);
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  assign ptr_next = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= SEED;
      ptr       <= 3'd0;
      gnt_o     <= '0;
      gnt_id_o  <= 3'd0;
      rnd_o     <= 4'h0;
      rnd_vld_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      // Seed load wins over any stepping of the generator.
      if (seed_load_i) begin
        q <= q_seed;
      end else begin
`ifdef LFSR_ARB_FREE_RUN_EN
        q <= q_next;
`else
        if (state == GNT) begin
          q <= q_next;
        end
`endif
      end

      case (state)
        IDLE: begin
          if (any_req && !seed_load_i) begin
            state     <= GNT;
            gnt_o     <= NUM_REQ'(1) << win;
            gnt_id_o  <= win;
            rnd_o     <= q;
            rnd_vld_o <= 1'b1;
            busy_o    <= 1'b1;
            ptr       <= ptr_next;
          end
        end
        GNT: begin
          state     <= IDLE;
          gnt_o     <= '0;
          rnd_vld_o <= 1'b0;
          busy_o    <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          gnt_o     <= '0;
          rnd_vld_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Self-checking bench for lfsr_rng_arbiter: a directed vector table,
// hand-written reset-mid-grant sequence, and a randomized run checked
// against a sequence-table reference model.

module tb_lfsr_rng_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [3:0]   seed;
  logic         ld;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_id;
  logic [3:0]   rnd;
  logic         rnd_vld;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(.NUM_REQ(N), .SEED(4'hE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .seed_i     (seed),
    .seed_load_i(ld),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id),
    .rnd_o      (rnd),
    .rnd_vld_o  (rnd_vld),
    .busy_o     (busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the generator is a position in the published
  // 15-value sequence; arbitration is a modulo scan from the pointer.
  logic [3:0] seq [15];
  int         m_pos;
  int         m_ptr;
  bit         m_busy;
  logic [3:0] m_gnt;
  int         m_id;
  logic [3:0] m_rnd;
  bit         m_vld;

  function automatic int pos_of(input logic [3:0] v);
    int p = 0;
    for (int k = 0; k < 15; k++) if (seq[k] == v) p = k;
    return p;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_ptr = 0; m_busy = 0; m_gnt = '0; m_id = 0; m_rnd = 4'h0; m_vld = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic l, input logic [3:0] s);
    bit was_busy = m_busy;
    if (!m_busy) begin
      if (r != 0 && !l) begin
        int w = -1;
        for (int k = 0; k < N; k++) begin
          int c = (m_ptr + k) % N;
          if (w < 0 && r[c]) w = c;
        end
        m_gnt  = N'(1) << w;
        m_id   = w;
        m_rnd  = seq[m_pos];
        m_vld  = 1;
        m_ptr  = (w + 1) % N;
        m_busy = 1;
      end else begin
        m_gnt = '0;
        m_vld = 0;
      end
    end else begin
      m_gnt  = '0;
      m_vld  = 0;
      m_busy = 0;
    end
    if (l) begin
      m_pos = pos_of((s == 4'h0) ? 4'hE : s);
    end else begin
`ifdef LFSR_ARB_FREE_RUN_EN
      m_pos = (m_pos + 1) % 15;
`else
      if (was_busy) m_pos = (m_pos + 1) % 15;
`endif
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic       ld;
    logic [3:0] seed;
    logic [3:0] gnt;
    logic [2:0] id;
    logic [3:0] rnd;
    logic       vld;
  } vec_t;

  vec_t tv [26];

  initial begin
    logic [N-1:0] pending;

    seq = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
            4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

    //          req     ld    seed   gnt     id    rnd   vld
    tv[0]  = '{4'b1111, 1'b0, 4'h0, 4'b0001, 3'd0, 4'hE, 1'b1};
    tv[1]  = '{4'b1110, 1'b0, 4'h0, 4'b0000, 3'd0, 4'hE, 1'b0};
    tv[2]  = '{4'b1110, 1'b0, 4'h0, 4'b0010, 3'd1, 4'hC, 1'b1};
    tv[3]  = '{4'b1100, 1'b0, 4'h0, 4'b0000, 3'd1, 4'hC, 1'b0};
    tv[4]  = '{4'b1100, 1'b0, 4'h0, 4'b0100, 3'd2, 4'h8, 1'b1};
    tv[5]  = '{4'b1000, 1'b0, 4'h0, 4'b0000, 3'd2, 4'h8, 1'b0};
    tv[6]  = '{4'b1001, 1'b0, 4'h0, 4'b1000, 3'd3, 4'h1, 1'b1};
    tv[7]  = '{4'b0001, 1'b0, 4'h0, 4'b0000, 3'd3, 4'h1, 1'b0};
    tv[8]  = '{4'b0001, 1'b0, 4'h0, 4'b0001, 3'd0, 4'h2, 1'b1};
    tv[9]  = '{4'b0000, 1'b0, 4'h0, 4'b0000, 3'd0, 4'h2, 1'b0};
    tv[10] = '{4'b1000, 1'b0, 4'h0, 4'b1000, 3'd3, 4'h4, 1'b1};
    tv[11] = '{4'b0101, 1'b0, 4'h0, 4'b0000, 3'd3, 4'h4, 1'b0};
    tv[12] = '{4'b0101, 1'b0, 4'h0, 4'b0001, 3'd0, 4'h9, 1'b1};
    tv[13] = '{4'b0100, 1'b0, 4'h0, 4'b0000, 3'd0, 4'h9, 1'b0};
    tv[14] = '{4'b0100, 1'b0, 4'h0, 4'b0100, 3'd2, 4'h3, 1'b1};
    tv[15] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 3'd2, 4'h3, 1'b0};
    tv[16] = '{4'b0010, 1'b1, 4'h9, 4'b0000, 3'd2, 4'h3, 1'b0};
    tv[17] = '{4'b0010, 1'b0, 4'h0, 4'b0010, 3'd1, 4'h9, 1'b1};
    tv[18] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 3'd1, 4'h9, 1'b0};
    tv[19] = '{4'b0010, 1'b0, 4'h0, 4'b0010, 3'd1, 4'h3, 1'b1};
    tv[20] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 3'd1, 4'h3, 1'b0};
    tv[21] = '{4'b0000, 1'b1, 4'h0, 4'b0000, 3'd1, 4'h3, 1'b0};
    tv[22] = '{4'b0001, 1'b0, 4'h0, 4'b0001, 3'd0, 4'hE, 1'b1};
    tv[23] = '{4'b0000, 1'b1, 4'h5, 4'b0000, 3'd0, 4'hE, 1'b0};
    tv[24] = '{4'b0100, 1'b0, 4'h0, 4'b0100, 3'd2, 4'h5, 1'b1};
    tv[25] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 3'd2, 4'h5, 1'b0};

    reset = 1'b1; req = '0; ld = 1'b0; seed = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst gnt",  8'(gnt), 8'h0);
    chk("rst id",   8'(gnt_id), 8'h0);
    chk("rst rnd",  8'(rnd), 8'h0);
    chk("rst vld",  8'(rnd_vld), 8'h0);
    chk("rst busy", 8'(busy), 8'h0);
    reset = 1'b0;

`ifdef LFSR_ARB_FREE_RUN_EN
    repeat (3) @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    chk("free-run rnd", 8'(rnd), 8'h1);
    chk("free-run vld", 8'(rnd_vld), 8'h1);
    req = '0;
    @(negedge clk);
`else
    for (int i = 0; i < 26; i++) begin
      req = tv[i].req; ld = tv[i].ld; seed = tv[i].seed;
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i),  8'(gnt), 8'(tv[i].gnt));
      chk($sformatf("vec%0d id", i),   8'(gnt_id), 8'(tv[i].id));
      chk($sformatf("vec%0d rnd", i),  8'(rnd), 8'(tv[i].rnd));
      chk($sformatf("vec%0d vld", i),  8'(rnd_vld), 8'(tv[i].vld));
      chk($sformatf("vec%0d busy", i), 8'(busy), 8'(tv[i].vld));
    end
    ld = 1'b0; seed = 4'h0; req = '0;
    @(negedge clk);
`endif

    // Reset in the middle of a grant cycle.
    req = 4'b0001;
    @(negedge clk);
    chk("pre-reset vld", 8'(rnd_vld), 8'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid-grant reset gnt",  8'(gnt), 8'h0);
    chk("mid-grant reset vld",  8'(rnd_vld), 8'h0);
    chk("mid-grant reset busy", 8'(busy), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset first gnt", 8'(gnt), 8'h1);
    chk("post-reset first rnd", 8'(rnd), 8'hE);

    // Randomized run against the reference model.
    reset = 1'b1; req = '0; ld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    pending = '0;
    for (int i = 0; i < 800; i++) begin
      pending &= ~m_gnt;
      if ($urandom_range(0, 2) == 0) pending |= N'($urandom_range(0, 15));
      ld   = ($urandom_range(0, 11) == 0);
      seed = 4'($urandom_range(0, 15));
      req  = pending;
      model_edge(req, ld, seed);
      @(negedge clk);
      chk($sformatf("rand%0d gnt", i),  8'(gnt), 8'(m_gnt));
      chk($sformatf("rand%0d vld", i),  8'(rnd_vld), 8'(m_vld));
      chk($sformatf("rand%0d busy", i), 8'(busy), 8'(m_busy));
      chk($sformatf("rand%0d id", i),   8'(gnt_id), 8'(m_id));
      chk($sformatf("rand%0d rnd", i),  8'(rnd), 8'(m_rnd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
